// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the FloPoCo-format floating-point operators.
//   - exception codes carried in the top two bits of every operand
//   - status-bit indices for the {invalid, overflow, underflow, inexact} vector
//   - exponent bias helper for an arbitrary exponent width
// No ports (package).
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam logic [1:0] EXN_ZERO   = 2'b00;
    localparam logic [1:0] EXN_NORMAL = 2'b01;
    localparam logic [1:0] EXN_INF    = 2'b10;
    localparam logic [1:0] EXN_NAN    = 2'b11;

    // Status vector layout: {invalid, overflow, underflow, inexact}
    localparam int ST_INEXACT   = 0;
    localparam int ST_UNDERFLOW = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_INVALID   = 3;
    localparam int ST_W         = 4;

    // Exponent bias for a WE-bit biased exponent: 2^(WE-1)-1
    function automatic int fp_bias(input int we);
        return (1 << (we - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_mul_pipe_round.sv
// -----------------------------------------------------------------------------
// fp_mul_pipe_round
// Combinational normalise / round-to-nearest-even / range check for the
// significand product of two normal operands.
//
// Parameters: WE exponent width, WF fraction width.
// Ports:
//   prod     in  2*WF+2  product of the two (WF+1)-bit significands (hidden 1s)
//   exp_raw  in  WE+2    Ex+Ey-bias, two's complement
//   exn      out 2       EXN_NORMAL, or EXN_INF on overflow, EXN_ZERO on underflow
//   exp      out WE      result exponent (zero when exn is not normal)
//   frac     out WF      result fraction (zero when exn is not normal)
//   flags    out 4       {invalid(always 0 here), overflow, underflow, inexact}
// -----------------------------------------------------------------------------
module fp_mul_pipe_round
    import fp_pkg::*;
#(
    parameter int WE = 8,
    parameter int WF = 23
) (
    input  logic [2*WF+1:0] prod,
    input  logic [WE+1:0]   exp_raw,
    output logic [1:0]      exn,
    output logic [WE-1:0]   exp,
    output logic [WF-1:0]   frac,
    output logic [ST_W-1:0] flags
);

    localparam int EW = WE + 2;
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << WE) - 1);

    logic                 norm;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic                 carry;
    logic                 ovf;
    logic                 unf;
    logic [WF-1:0]        frac_t;
    logic [WF:0]          frac_r;
    logic signed [EW-1:0] exp_val;

    always_comb begin
        // Product lies in [1,4): bit 2WF+1 set means it needs a right shift.
        norm = prod[2*WF+1];
        if (norm) begin
            frac_t = prod[2*WF:WF+1];
            guard  = prod[WF];
            sticky = |prod[WF-1:0];
        end else begin
            frac_t = prod[2*WF-1:WF];
            guard  = prod[WF-1];
            sticky = |prod[WF-2:0];
        end

        // Ties go to the even fraction (lsb 0).
        round_up = guard & (sticky | frac_t[0]);
        frac_r   = {1'b0, frac_t} + {{WF{1'b0}}, round_up};
        // A carry out leaves frac_r[WF-1:0] all zero, which is the right fraction.
        carry    = frac_r[WF];

        exp_val = exp_raw + EW'(norm) + EW'(carry);
        ovf     = exp_val > EXP_MAX;
        unf     = exp_val < 0;

        flags               = '0;
        flags[ST_OVERFLOW]  = ovf;
        flags[ST_UNDERFLOW] = unf;
        // Overflow to infinity and flush to zero both lose the value.
        flags[ST_INEXACT]   = guard | sticky | ovf | unf;

        if (ovf) begin
            exn  = EXN_INF;
            exp  = '0;
            frac = '0;
        end else if (unf) begin
            exn  = EXN_ZERO;
            exp  = '0;
            frac = '0;
        end else begin
            exn  = EXN_NORMAL;
            exp  = exp_val[WE-1:0];
            frac = frac_r[WF-1:0];
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// -----------------------------------------------------------------------------
// fp_mul_pipe
// Pipelined FloPoCo-format floating-point multiplier with valid/ready
// handshake on both sides and full backpressure.
//
// Operand format: {exn[1:0], sign, exp[WE-1:0], frac[WF-1:0]}, W = WE+WF+3.
// Parameters: WE (3..15), WF (2..52), NUM_STAGES (0..8).
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (clears stage valids only)
//   in_valid   in   X/Y valid
//   in_ready   out  operand pair accepted when in_valid & in_ready
//   X, Y       in   operands (W bits)
//   out_valid  out  R valid
//   out_ready  in   R consumed when out_valid & out_ready
//   R          out  product (W bits)
// Optional (macro FP_MUL_PIPE_STATUS_EN):
//   status     out  {invalid, overflow, underflow, inexact}, valid with R
//   status_clr in   clears the internal sticky status register
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; stage i loads when it is empty or its content moves onward in
// the same cycle, so bubbles collapse and results leave in acceptance order.
//
// Slice placement: slice 0 after exception decode + significand product,
// slice 1 after normalise/round, any further slices appended at the output.
// NUM_STAGES = 0 makes the block purely combinational.
// -----------------------------------------------------------------------------
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter  int WE         = 8,
    parameter  int WF         = 23,
    parameter  int NUM_STAGES = 1,
    localparam int W          = WE + WF + 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef FP_MUL_PIPE_STATUS_EN
    output logic [ST_W-1:0] status,
    input  logic            status_clr,
`endif
    output logic [W-1:0] R
);

    localparam int PW = 2 * WF + 2;
    localparam int EW = WE + 2;
    localparam logic [EW-1:0] BIAS = EW'(fp_bias(WE));
`ifdef FP_MUL_PIPE_STATUS_EN
    localparam int PB = W + ST_W;
`else
    localparam int PB = W;
`endif

    // ---------------- exception decode and significand product ----------------
    logic [1:0]    x_exn, y_exn;
    logic          x_sign, y_sign;
    logic [WE-1:0] x_exp, y_exp;
    logic [WF-1:0] x_frac, y_frac;

    assign {x_exn, x_sign, x_exp, x_frac} = X;
    assign {y_exn, y_sign, y_exp, y_frac} = Y;

    logic [1:0]    d_exn;
    logic          d_sign;
    logic [PW-1:0] d_prod;
    logic [EW-1:0] d_exp;

    always_comb begin
        d_sign = x_sign ^ y_sign;
        if (x_exn == EXN_NAN || y_exn == EXN_NAN) begin
            d_exn = EXN_NAN;
        end else if ((x_exn == EXN_INF && y_exn == EXN_ZERO) ||
                     (x_exn == EXN_ZERO && y_exn == EXN_INF)) begin
            d_exn = EXN_NAN;
        end else if (x_exn == EXN_INF || y_exn == EXN_INF) begin
            d_exn = EXN_INF;
        end else if (x_exn == EXN_ZERO || y_exn == EXN_ZERO) begin
            d_exn = EXN_ZERO;
        end else begin
            // EXN_NORMAL here means "take the arithmetic path".
            d_exn = EXN_NORMAL;
        end
        d_prod = PW'({1'b1, x_frac}) * PW'({1'b1, y_frac});
        d_exp  = EW'(x_exp) + EW'(y_exp) - BIAS;
    end

    // ---------------- slice 0 outputs (registered or pass-through) -----------
    logic [1:0]    a_exn;
    logic          a_sign;
    logic [PW-1:0] a_prod;
    logic [EW-1:0] a_exp;

    // ---------------- normalise / round ----------------
    logic [1:0]      rnd_exn;
    logic [WE-1:0]   rnd_exp;
    logic [WF-1:0]   rnd_frac;
    logic [ST_W-1:0] rnd_flags;

    fp_mul_pipe_round #(
        .WE (WE),
        .WF (WF)
    ) u_round (
        .prod    (a_prod),
        .exp_raw (a_exp),
        .exn     (rnd_exn),
        .exp     (rnd_exp),
        .frac    (rnd_frac),
        .flags   (rnd_flags)
    );

    logic [W-1:0]  r_d;
    logic [PB-1:0] b_d;

    always_comb begin
        if (a_exn == EXN_NORMAL) begin
            r_d = {rnd_exn, a_sign, rnd_exp, rnd_frac};
        end else begin
            r_d = {a_exn, a_sign, {(WE + WF){1'b0}}};
        end
    end

`ifdef FP_MUL_PIPE_STATUS_EN
    logic [ST_W-1:0] st_d;

    always_comb begin
        if (a_exn == EXN_NORMAL) begin
            st_d = rnd_flags;
        end else begin
            // Every NaN result comes from a NaN-producing exception entry.
            st_d              = '0;
            st_d[ST_INVALID]  = (a_exn == EXN_NAN);
        end
    end

    assign b_d = {st_d, r_d};
`else
    assign b_d = r_d;
`endif

    // ---------------- stage chain ----------------
    logic [PB-1:0] b_out;

    generate
        if (NUM_STAGES == 0) begin : g_comb
            assign a_exn     = d_exn;
            assign a_sign    = d_sign;
            assign a_prod    = d_prod;
            assign a_exp     = d_exp;
            assign b_out     = b_d;
            assign in_ready  = out_ready;
            assign out_valid = in_valid;
        end else begin : g_pipe
            logic [NUM_STAGES-1:0] vld;
            // rdy[i]: stage i may load this cycle; rdy[NUM_STAGES] is the consumer.
            logic [NUM_STAGES:0]   rdy;

            assign rdy[NUM_STAGES] = out_ready;
            for (genvar i = 0; i < NUM_STAGES; i++) begin : g_rdy
                assign rdy[i] = !vld[i] || rdy[i+1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld <= '0;
                end else begin
                    if (rdy[0]) vld[0] <= in_valid;
                    for (int i = 1; i < NUM_STAGES; i++) begin
                        if (rdy[i]) vld[i] <= vld[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rdy[0] && in_valid) begin
                    a_exn  <= d_exn;
                    a_sign <= d_sign;
                    a_prod <= d_prod;
                    a_exp  <= d_exp;
                end
            end

            if (NUM_STAGES == 1) begin : g_one
                assign b_out = b_d;
            end else begin : g_more
                // b_q[k] is the data register of stage k+1.
                logic [PB-1:0] b_q [NUM_STAGES-1];

                always_ff @(posedge clk) begin
                    if (rdy[1] && vld[0]) b_q[0] <= b_d;
                    for (int k = 1; k < NUM_STAGES - 1; k++) begin
                        if (rdy[k+1] && vld[k]) b_q[k] <= b_q[k-1];
                    end
                end

                assign b_out = b_q[NUM_STAGES-2];
            end

            assign in_ready  = rdy[0];
            assign out_valid = vld[NUM_STAGES-1];
        end
    endgenerate

    assign R = b_out[W-1:0];

`ifdef FP_MUL_PIPE_STATUS_EN
    assign status = b_out[PB-1:W];

    // Sticky flags accumulate over output transfers; a clear in the same
    // cycle as a transfer keeps only the new flags.
    logic [ST_W-1:0] sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= '0;
        end else if (out_valid && out_ready) begin
            sticky <= status_clr ? status : (sticky | status);
        end else if (status_clr) begin
            sticky <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_pipe
// Self-checking bench for fp_mul_pipe (WE=8, WF=23, NUM_STAGES=3).
// Directed vectors carry hand-derived expectations; random vectors are
// checked against a real-arithmetic reference model. A monitor pops the
// expected queue on every output transfer.
// -----------------------------------------------------------------------------
module tb_fp_mul_pipe;

  localparam int WE = 8;
  localparam int WF = 23;
  localparam int NS = 3;
  localparam int W  = WE + WF + 3;
  localparam logic [WE+WF-1:0] ZF = '0;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] X = '0;
  logic [W-1:0] Y = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] R;
`ifdef FP_MUL_PIPE_STATUS_EN
  logic [3:0]   status;
  logic         status_clr = 1'b0;
`endif

  always #5 clk = ~clk;

  fp_mul_pipe #(
    .WE         (WE),
    .WF         (WF),
    .NUM_STAGES (NS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .X          (X),
    .Y          (Y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef FP_MUL_PIPE_STATUS_EN
    .status     (status),
    .status_clr (status_clr),
`endif
    .R          (R)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_low = -1;
  int mode = 0;

  // Expected entries: {status[3:0], R[W-1:0]}
  logic [W+3:0] exp_q[$];
  int           acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [W+3:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [1:0] xn, yn;
    logic       s, inx;
    int         e, fi;
    real        mx, my, p, f, rem;
    xn = x[W-1:W-2];
    yn = y[W-1:W-2];
    s  = x[W-3] ^ y[W-3];
    if (xn == 2'b11 || yn == 2'b11 || (xn == 2'b10 && yn == 2'b00) || (xn == 2'b00 && yn == 2'b10))
      return {4'b1000, 2'b11, s, ZF};
    if (xn == 2'b10 || yn == 2'b10) return {4'b0000, 2'b10, s, ZF};
    if (xn == 2'b00 || yn == 2'b00) return {4'b0000, 2'b00, s, ZF};
    mx = 1.0 + real'(x[WF-1:0]) / 8388608.0;
    my = 1.0 + real'(y[WF-1:0]) / 8388608.0;
    p  = mx * my;
    e  = int'(x[WE+WF-1:WF]) + int'(y[WE+WF-1:WF]) - 127;
    if (p >= 2.0) begin
      p = p / 2.0;
      e++;
    end
    f   = (p - 1.0) * 8388608.0;
    fi  = $rtoi(f);
    rem = f - real'(fi);
    inx = (rem != 0.0);
    if (rem > 0.5 || (rem == 0.5 && (fi % 2) == 1)) fi++;
    if (fi == 8388608) begin
      fi = 0;
      e++;
    end
    if (e > 255) return {4'b0101, 2'b10, s, ZF};
    if (e < 0) return {4'b0011, 2'b00, s, ZF};
    return {3'b000, inx, 2'b01, s, 8'(e), 23'(fi)};
  endfunction

  function automatic logic [W-1:0] rand_op(input bit near);
    logic [1:0]  xn;
    logic [7:0]  e;
    logic [22:0] f;
    logic        s;
    int          k;
    k  = $urandom_range(0, 15);
    xn = (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : (k == 2) ? 2'b11 : 2'b01;
    if (near) xn = 2'b01;
    if (near || $urandom_range(0, 3) != 0) e = 8'($urandom_range(90, 165));
    else e = 8'($urandom_range(0, 255));
    f = 23'($urandom);
    s = 1'($urandom);
    return {xn, s, e, f};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_exp(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W+3:0] e);
    int n;
    int acc;
    n = 0;
    X = x;
    Y = y;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    exp_q.push_back(e);
    acc_q.push_back(acc);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    send_exp(x, y, model(x, y));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Consumer: 0 always ready, 1 ready one cycle in three, 2 random, 3 stalled
  always @(posedge clk) begin
    #1;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = (cyc % 3 == 0);
      2: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard monitor ----------------
  logic [W+3:0] m_exp;
  int           m_acc;

  always @(negedge clk) begin
    if (rst_n) begin
      // in_ready may only drop while every stage holds a result and the consumer stalls
      checks++;
      if (in_ready !== !(exp_q.size() == NS && !out_ready)) begin
        failures++;
        $display("FAIL in_ready: got %b with %0d in flight out_ready=%b", in_ready, exp_q.size(), out_ready);
      end
      if (out_valid && exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: out_valid=1 R=%h, required no result pending", R);
      end else if (out_valid && out_ready) begin
        m_exp = exp_q.pop_front();
        m_acc = acc_q.pop_front();
        checks++;
        if (R !== m_exp[W-1:0]) begin
          failures++;
          $display("FAIL result: got R=%h, required R=%h", R, m_exp[W-1:0]);
        end
`ifdef FP_MUL_PIPE_STATUS_EN
        checks++;
        if (status !== m_exp[W+3:W]) begin
          failures++;
          $display("FAIL status: got %b, required %b", status, m_exp[W+3:W]);
        end
`endif
        if (last_low < m_acc) begin
          checks++;
          if (cyc - m_acc != NS) begin
            failures++;
            $display("FAIL latency: got %0d cycles, required %0d", cyc - m_acc, NS);
          end
        end
      end
      if (!out_ready) last_low = cyc;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    #3;
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with hand-derived results, consumer always ready
    send_exp(34'h13FC00000, 34'h140000000, {4'b0000, 34'h140400000}); // 1.5*2.0=3.0
    send_exp(34'h200000000, 34'h000000000, {4'b1000, 34'h300000000}); // inf*0=NaN
    send_exp(34'h17F800000, 34'h17F800000, {4'b0101, 34'h200000000}); // overflow
    send_exp(34'h100800000, 34'h100800000, {4'b0011, 34'h000000000}); // underflow
    send_exp(34'h13F800001, 34'h13FC00000, {4'b0001, 34'h13FC00002}); // tie, round up to even
    send_exp(34'h13F800002, 34'h13FA00000, {4'b0001, 34'h13FA00002}); // tie, stays even
    send_exp(34'h13FFFFFFF, 34'h13F800001, {4'b0001, 34'h140000000}); // rounding carry
    send_exp(34'h1BFC00000, 34'h140000000, {4'b0000, 34'h1C0400000}); // -1.5*2.0
    send_exp(34'h380000000, 34'h13FC00000, {4'b1000, 34'h380000000}); // NaN in, sign 1
    send_exp(34'h080000000, 34'h200000000, {4'b1000, 34'h380000000}); // -0*inf
    send_exp(34'h200000000, 34'h1BFC00000, {4'b0000, 34'h280000000}); // inf*-1.5
    send_exp(34'h000000000, 34'h13FC00000, {4'b0000, 34'h000000000}); // 0*1.5
    send_exp(34'h17F800000, 34'h13F800000, {4'b0000, 34'h17F800000}); // max exponent kept
    send_exp(34'h100800000, 34'h13F000000, {4'b0000, 34'h100000000}); // exponent 0 kept
    idle(6);

    // Random operands, random gaps, random backpressure
    mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(rand_op(1'b0), rand_op(1'b0));
    end
    idle(1);

    // Eight back-to-back pairs under one-in-three backpressure
    mode = 1;
    for (int i = 0; i < 8; i++) send(rand_op(1'b1), rand_op(1'b1));
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;

    // Reset with two operations in flight
    mode = 3;
    @(posedge clk);
    #1;
    send(rand_op(1'b1), rand_op(1'b1));
    send(rand_op(1'b1), rand_op(1'b1));
    idle(4);
    check_bit("stalled_out_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("midreset_out_valid", out_valid, 1'b0);
    check_bit("midreset_in_ready", in_ready, 1'b1);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    @(posedge clk);
    #1;
    send_exp(34'h13FC00000, 34'h140000000, {4'b0000, 34'h140400000});
    send(rand_op(1'b0), rand_op(1'b0));
    in_valid = 1'b0;

    // Drain
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised pipelined floating-point multiplier for the FloPoCo operand format: 2 exception bits, sign, WE-bit biased exponent, WF-bit fraction. It generalises the fixed single-precision multiplier variants in four ways:

- arbitrary exponent and fraction widths;
- any pipeline depth from 0 upward;
- a valid/ready handshake with full backpressure instead of a global clock enable;
- asynchronous reset of all control state.

It sits between operand-producing datapath stages and result consumers in the FP operator library.

## Interface
- WE, default 8: exponent width, 3..15.
- WF, default 23: fraction width, 2..52.
- NUM_STAGES, default 1: pipeline register slices, 0..8.
- W, default WE+WF+3: derived operand width, not overridable.

- clk  in  1  clock; every register is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  X/Y are valid this cycle.
- in_ready  out  1  block accepts an operand pair this cycle.
- X  in  W  operand, FloPoCo format {exn[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
- Y  in  W  operand, same format.
- out_valid  out  1  R is valid this cycle.
- out_ready  in  1  consumer accepts R this cycle.
- R  out  W  product.

## Operation
- Exception codes: 00 zero, 01 normal, 10 infinity, 11 NaN.
- Result sign is always sign(X) XOR sign(Y), including zero, infinity and NaN results.
- Exception table:
  - NaN on either input gives NaN.
  - Infinity times zero gives NaN.
  - Infinity times normal or infinity gives infinity.
  - Zero times normal or zero gives zero.
  - Normal times normal goes to the arithmetic path.
- Arithmetic path:
  - bias = 2^(WE-1)-1.
  - Form the (WF+1)x(WF+1) significand product with hidden 1s.
  - If product bit 2WF+1 is set, shift right by 1 and add 1 to the exponent.
  - Round to nearest, ties to even, using guard bit plus sticky OR of all lower bits.
  - If rounding carries out of the significand, increment the exponent and zero the fraction.
- Exponent is computed in WE+2 signed bits as Ex+Ey-bias+norm+roundcarry.
  - Value > 2^WE-1: result is infinity (overflow).
  - Value < 0: result is zero (underflow flush). The block produces no subnormals.
- When an exception result is produced, exp and frac of R are all zeros.
- Handshake:
  - A transfer occurs on a cycle where valid and ready are both high, on each side.
  - Results leave in acceptance order, with no loss and no duplication.
- Each stage holds a valid bit. Stage i loads when it is empty or stage i+1 (or the output) is transferring. Bubbles collapse.
- in_ready = (stage 0 empty) OR (stage 0 advancing).
- NUM_STAGES=0: purely combinational. in_ready=out_ready, out_valid=in_valid, R=f(X,Y).
- Register placement:
  - The first slice follows the significand product and exception decode.
  - The second slice follows normalise/round.
  - Further slices are appended at the output.

## Timing
- Latency is NUM_STAGES cycles from an input transfer to out_valid, when out_ready is held high.
- Throughput is one result per cycle under no backpressure.
- During reset (rst_n low), independent of clk:
  - all stage valids clear;
  - out_valid=0;
  - in_ready=1 for NUM_STAGES>0.
- Data registers are not reset. R is don't-care while out_valid=0.
- Reset asserted mid-stream discards all in-flight operations. After release, the first accepted pair emerges after NUM_STAGES cycles.
- With all stages full and out_ready low, in_ready=0. Contents hold unchanged until out_ready rises.
- In the same cycle as an output transfer, a new input may be accepted into the freed chain.

## Configuration
- Macro: FP_MUL_PIPE_STATUS_EN.
- When defined, two extra ports exist:
  - status out 4 {invalid, overflow, underflow, inexact}, valid alongside R; invalid means the result came from a NaN-producing exception-table entry.
  - status_clr in 1 clears the sticky register.
- Also when defined, an internal sticky register ORs in status on every output transfer. Its reset value is 0. If status_clr and a transfer coincide, only the new flags remain.
- When undefined, these ports and registers do not exist. Core behaviour is identical.

## Structure
- Package fp_pkg holds:
  - exception code constants EXN_ZERO, EXN_NORMAL, EXN_INF, EXN_NAN;
  - a parameterised bias function;
  - the status-bit index constants.
- One sub-module, fp_mul_pipe_round: the combinational normalise/round/overflow block. Parameters WE, WF. Input: the significand product and raw exponent. Output: {exn, exp, frac, flags}.
- Top level holds exception decode, the multiplier, the stage valid/ready chain and the data registers.

## Test plan
- WE=8, WF=23, NUM_STAGES=1. X=0x13FC00000 (1.5), Y=0x140000000 (2.0) -> R=0x140400000 (3.0) one cycle after acceptance.
- X=infinity 0x200000000, Y=zero 0x000000000 -> R exn=11, sign 0. With FP_MUL_PIPE_STATUS_EN defined, invalid=1.
- X=Y={01,0,0xFF,0} -> overflow. R=0x200000000; overflow=1, inexact=1.
- X=Y={01,0,0x01,0} -> underflow. R=0x000000000; underflow=1.
- NUM_STAGES=3. Send 8 back-to-back pairs while toggling out_ready with a 1-of-3 pattern. Required: all 8 products correct and in order; in_ready=0 only while 3 stages are full and out_ready=0.
- NUM_STAGES=3. Assert rst_n low with 2 operations in flight -> out_valid drops immediately, those results never appear, and the next accepted pair emerges 3 cycles after acceptance.
